// File: rtl/mem_burst_master_pkg.sv
// rtl/mem_burst_master_pkg.sv - shared state encoding and default widths for the burst master
package mem_burst_master_pkg;

    localparam int A_DEF = 12;
    localparam int M_DEF = 16;
    localparam int L_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/mem_burst_rd_buf.sv
// rtl/mem_burst_rd_buf.sv - single-entry registered read output with valid/ready hold
module mem_burst_rd_buf #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         rd_ready,
    output logic         rd_valid,
    output logic [W-1:0] rd_data
);

    // A load in the same cycle as a consume wins, so back-to-back words keep rd_valid high.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (load) begin
            rd_valid <= 1'b1;
            rd_data  <= load_data;
        end else if (rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst read/write initiator for a single-port word memory (optional BOUNDS_CHECK_EN)
module mem_burst_master
    import mem_burst_master_pkg::*;
#(
    parameter int A = A_DEF,
    parameter int m = M_DEF,
    parameter int L = L_DEF
) (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [A-1:0] req_addr,
    input  logic [L-1:0] req_len,
    input  logic [m-1:0] wr_data,
    input  logic         wr_valid,
    output logic         wr_ready,
    output logic [m-1:0] rd_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic         busy,
    output logic         done,
`ifdef BOUNDS_CHECK_EN
    output logic         err,
`endif
    output logic [A-1:0] mem_address,
    output logic [m-1:0] mem_data_in,
    output logic         mem_write_enable,
    output logic         mem_read_enable,
    input  logic [m-1:0] mem_data_out
);

    localparam logic [A-1:0] ADDR_ONE = {{(A-1){1'b0}}, 1'b1};
    localparam logic [L-1:0] CNT_ONE  = {{(L-1){1'b0}}, 1'b1};

    state_t       state, state_nxt;
    logic [A-1:0] cur_addr, addr_nxt;
    logic [L-1:0] cnt, cnt_nxt;
    logic         done_nxt;
    logic         issue;
    logic         err_nxt;

`ifdef BOUNDS_CHECK_EN
    logic [A:0] end_addr;
    logic       over;
    assign end_addr = {1'b0, req_addr} + (A+1)'(req_len);
    assign over     = end_addr[A];
`endif

    always_comb begin
        state_nxt        = state;
        addr_nxt         = cur_addr;
        cnt_nxt          = cnt;
        done_nxt         = 1'b0;
        err_nxt          = 1'b0;
        issue            = 1'b0;
        req_ready        = 1'b0;
        wr_ready         = 1'b0;
        mem_address      = '0;
        mem_data_in      = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
`ifdef BOUNDS_CHECK_EN
                    if (over) err_nxt = 1'b1;
                    else
`endif
                    begin
                        addr_nxt  = req_addr;
                        cnt_nxt   = req_len;
                        state_nxt = req_write ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                // Strobes follow wr_valid directly so memory commits on the handshake edge.
                wr_ready         = 1'b1;
                mem_address      = cur_addr;
                mem_data_in      = wr_data;
                mem_write_enable = wr_valid;
                if (wr_valid) begin
                    if (cnt == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt  = cnt - CNT_ONE;
                        addr_nxt = cur_addr + ADDR_ONE;
                    end
                end
            end
            READ: begin
                mem_read_enable = 1'b1;
                mem_address     = cur_addr;
                issue           = !rd_valid || rd_ready;
                if (issue) begin
                    if (cnt == '0) begin
                        state_nxt = DRAIN;
                    end else begin
                        cnt_nxt  = cnt - CNT_ONE;
                        addr_nxt = cur_addr + ADDR_ONE;
                    end
                end
            end
            DRAIN: begin
                if (rd_valid && rd_ready) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state    <= IDLE;
            cur_addr <= '0;
            cnt      <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur_addr <= addr_nxt;
            cnt      <= cnt_nxt;
            done     <= done_nxt;
        end
    end

`ifdef BOUNDS_CHECK_EN
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) err <= 1'b0;
        else        err <= err_nxt;
    end
`else
    logic unused_err;
    assign unused_err = err_nxt;
`endif

    assign busy = (state != IDLE);

    mem_burst_rd_buf #(.W(m)) u_rd_buf (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .load      (issue),
        .load_data (mem_data_out),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
    );

endmodule

// File: tb/tb_mem_burst_master.sv
// tb/tb_mem_burst_master.sv - directed self-checking bench for mem_burst_master
module tb_mem_burst_master;

    localparam int A = 12;
    localparam int M = 16;
    localparam int L = 4;

    logic         CLK = 1'b0;
    logic         RST_n;
    logic         req_valid, req_ready, req_write;
    logic [A-1:0] req_addr;
    logic [L-1:0] req_len;
    logic [M-1:0] wr_data;
    logic         wr_valid, wr_ready;
    logic [M-1:0] rd_data;
    logic         rd_valid, rd_ready;
    logic         busy, done;
`ifdef BOUNDS_CHECK_EN
    logic         err;
`endif
    logic [A-1:0] mem_address;
    logic [M-1:0] mem_data_in, mem_data_out;
    logic         mem_write_enable, mem_read_enable;

    logic [M-1:0] mem [0:4095];
    logic         pre_we;
    logic [A-1:0] pre_addr;
    logic [M-1:0] pre_data;
    logic         log_clr;
    int           wcount;
    int           ccount;
    logic [M-1:0] clog [0:7];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    mem_burst_master #(.A(A), .m(M), .L(L)) dut (
        .CLK              (CLK),
        .RST_n            (RST_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_len          (req_len),
        .wr_data          (wr_data),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .busy             (busy),
        .done             (done),
`ifdef BOUNDS_CHECK_EN
        .err              (err),
`endif
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_data_out     (mem_data_out)
    );

    always @(posedge CLK) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_write_enable) mem[mem_address] <= mem_data_in;
    end
    assign mem_data_out = mem_read_enable ? mem[mem_address] : '0;

    always @(posedge CLK) begin
        if (log_clr) begin
            wcount <= 0;
            ccount <= 0;
        end else begin
            if (mem_write_enable) wcount <= wcount + 1;
            if (rd_valid && rd_ready) begin
                clog[ccount[2:0]] <= rd_data;
                ccount <= ccount + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [A-1:0] a, input logic [M-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic clear_logs();
        log_clr = 1'b1;
        tick();
        log_clr = 1'b0;
    endtask

    task automatic request(input logic w, input logic [A-1:0] a, input logic [L-1:0] n);
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = n;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        RST_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0; log_clr = 1'b1;
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_we", mem_write_enable, 0);
        chk("rst_mem_re", mem_read_enable, 0);
        chk("rst_mem_addr", mem_address, 0);
        RST_n = 1'b1;
        tick();
        log_clr = 1'b0;

        // write burst 0x1F4, 3 words
        request(1'b1, 12'h1F4, 4'd2);
        #1 chk("wr_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0; wr_valid = 1'b1; wr_data = 16'hAAAA;
        #1 chk("wr_wr_ready", wr_ready, 1);
        chk("wr_mem_we", mem_write_enable, 1);
        chk("wr_addr0", mem_address, 12'h1F4);
        chk("wr_data_in", mem_data_in, 16'hAAAA);
        chk("wr_busy", busy, 1);
        chk("wr_req_ready_busy", req_ready, 0);
        tick();
        wr_data = 16'hBBBB;
        #1 chk("wr_addr1", mem_address, 12'h1F5);
        tick();
        wr_data = 16'hCCCC;
        #1 chk("wr_addr2", mem_address, 12'h1F6);
        tick();
        wr_valid = 1'b0;
        #1 chk("wr_done", done, 1);
        chk("wr_busy_at_done", busy, 0);
        chk("wr_mem_we_idle", mem_write_enable, 0);
        chk("wr_count", wcount, 3);
        chk("wr_mem0", mem[12'h1F4], 16'hAAAA);
        chk("wr_mem1", mem[12'h1F5], 16'hBBBB);
        chk("wr_mem2", mem[12'h1F6], 16'hCCCC);
        tick();
        chk("wr_done_clear", done, 0);

        // read burst, consumer always ready
        preload(12'h1F4, 16'h1010);
        preload(12'h1F5, 16'h0101);
        preload(12'h1F6, 16'h1234);
        clear_logs();
        rd_ready = 1'b1;
        request(1'b0, 12'h1F4, 4'd2);
        tick();
        req_valid = 1'b0;
        #1 chk("rd_mem_re", mem_read_enable, 1);
        chk("rd_addr0", mem_address, 12'h1F4);
        chk("rd_valid_pre", rd_valid, 0);
        tick();
        chk("rd_valid0", rd_valid, 1);
        chk("rd_data0", rd_data, 16'h1010);
        chk("rd_addr1", mem_address, 12'h1F5);
        tick();
        chk("rd_data1", rd_data, 16'h0101);
        tick();
        chk("rd_data2", rd_data, 16'h1234);
        chk("rd_valid2", rd_valid, 1);
        chk("drain_mem_re", mem_read_enable, 0);
        chk("drain_addr", mem_address, 0);
        chk("drain_busy", busy, 1);
        tick();
        chk("rd_done", done, 1);
        chk("rd_busy_at_done", busy, 0);
        chk("rd_valid_after", rd_valid, 0);
        chk("rd_ccount", ccount, 3);
        chk("rd_clog0", clog[0], 16'h1010);
        chk("rd_clog1", clog[1], 16'h0101);
        chk("rd_clog2", clog[2], 16'h1234);
        tick();
        chk("rd_done_clear", done, 0);

        // read burst with 3 cycles of backpressure after the first word
        clear_logs();
        request(1'b0, 12'h1F4, 4'd2);
        tick();
        req_valid = 1'b0;
        tick();
        rd_ready = 1'b0;
        #1 chk("bp_first", rd_data, 16'h1010);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_data", rd_data, 16'h1010);
            chk("bp_hold_valid", rd_valid, 1);
            chk("bp_hold_re", mem_read_enable, 1);
            chk("bp_hold_addr", mem_address, 12'h1F5);
        end
        rd_ready = 1'b1;
        tick();
        chk("bp_data1", rd_data, 16'h0101);
        chk("bp_addr2", mem_address, 12'h1F6);
        tick();
        chk("bp_data2", rd_data, 16'h1234);
        tick();
        chk("bp_done", done, 1);
        chk("bp_ccount", ccount, 3);
        chk("bp_clog0", clog[0], 16'h1010);
        chk("bp_clog1", clog[1], 16'h0101);
        chk("bp_clog2", clog[2], 16'h1234);
        tick();

        // address wrap at the top of memory
        preload(12'hFFF, 16'h5A5A);
        preload(12'h000, 16'hA5A5);
        clear_logs();
        request(1'b0, 12'hFFF, 4'd1);
        tick();
        req_valid = 1'b0;
`ifdef BOUNDS_CHECK_EN
        #1 chk("bc_err", err, 1);
        chk("bc_busy", busy, 0);
        chk("bc_req_ready", req_ready, 1);
        tick();
        chk("bc_err_clear", err, 0);
        chk("bc_no_done", done, 0);
        chk("bc_no_access", ccount, 0);
        tick();
        chk("bc_no_done2", done, 0);
`else
        #1 chk("wrap_addr0", mem_address, 12'hFFF);
        tick();
        chk("wrap_data0", rd_data, 16'h5A5A);
        chk("wrap_addr1", mem_address, 12'h000);
        tick();
        chk("wrap_data1", rd_data, 16'hA5A5);
        tick();
        chk("wrap_done", done, 1);
        tick();
`endif

        // reset during the second beat of a 4-word write
        clear_logs();
        request(1'b1, 12'h100, 4'd3);
        tick();
        req_valid = 1'b0; wr_valid = 1'b1; wr_data = 16'h1111;
        tick();
        wr_data = 16'h2222;
        #1 chk("mid_we", mem_write_enable, 1);
        chk("mid_addr", mem_address, 12'h101);
        RST_n = 1'b0;
        #1 chk("mid_rst_we", mem_write_enable, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_addr", mem_address, 0);
        wr_valid = 1'b0;
        tick();
        RST_n = 1'b1;
        chk("mid_wcount", wcount, 1);

        // single-word write, then a read accepted in the done cycle
        request(1'b1, 12'h200, 4'd0);
        tick();
        req_valid = 1'b0; wr_valid = 1'b1; wr_data = 16'hBEEF;
        #1 chk("one_wr_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        request(1'b0, 12'h200, 4'd0);
        rd_ready = 1'b1;
        #1 chk("one_done", done, 1);
        chk("b2b_req_ready", req_ready, 1);
        chk("one_mem", mem[12'h200], 16'hBEEF);
        tick();
        req_valid = 1'b0;
        #1 chk("b2b_done_clear", done, 0);
        chk("b2b_busy", busy, 1);
        chk("b2b_re", mem_read_enable, 1);
        tick();
        chk("b2b_data", rd_data, 16'hBEEF);
        tick();
        chk("b2b_done", done, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
